// File: rtl/keypad_bus_reader_pkg.sv
// keypad_bus_reader_pkg
// Shared definitions for the keypad bus reader:
//   - register offsets relative to the peripheral base address
//   - scan FSM state encodings
//   - the 5-bit raw code sentinel for "no key" (MSB set)
//   - helpers for column drive decode and first-key search
package keypad_bus_reader_pkg;

  localparam logic [7:0] STATUS_OFS = 8'd0;
  localparam logic [7:0] KEY_OFS    = 8'd1;

  typedef enum logic [2:0] {
    DRIVE0 = 3'd0,
    DRIVE1 = 3'd1,
    DRIVE2 = 3'd2,
    DRIVE3 = 3'd3,
    EVAL   = 3'd4
  } scan_state_e;

  // Raw code is {none, col[1:0], row[1:0]}; MSB set means no key down.
  localparam logic [4:0] CODE_NONE = 5'b1_0000;

  // All columns released while the scan is being evaluated.
  localparam logic [3:0] COL_IDLE = 4'b1111;

  // Active-low one-hot column drive for a given scan state.
  function automatic logic [3:0] col_drive(input scan_state_e s);
    logic [3:0] col;
    case (s)
      DRIVE0:  col = 4'b1110;
      DRIVE1:  col = 4'b1101;
      DRIVE2:  col = 4'b1011;
      DRIVE3:  col = 4'b0111;
      default: col = COL_IDLE;
    endcase
    return col;
  endfunction

  // First asserted (low) key, lowest column first, then lowest row.
  // Iterating from the highest index down lets the lowest hit win.
  function automatic logic [4:0] first_key(input logic [3:0][3:0] caps);
    logic [4:0] code;
    code = CODE_NONE;
    for (int c = 3; c >= 0; c--) begin
      for (int r = 3; r >= 0; r--) begin
        if (!caps[c][r]) begin
          code = {1'b0, 2'(c), 2'(r)};
        end
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_bus_reader_if.sv
// keypad_bus_reader_if
// Address/control half of the 8-bit processor bus.
//   BUS_ADDR : processor address
//   BUS_WE   : 1 = write, 0 = read
// The bidirectional BUS_DATA net is a plain inout port of the peripheral
// so that the tristate resolution stays at a module boundary.
// Modports: master (processor side), slave (peripheral side).
interface keypad_bus_reader_if;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;

  modport master (output BUS_ADDR, output BUS_WE);
  modport slave  (input  BUS_ADDR, input  BUS_WE);
endinterface

// File: rtl/keypad_bus_reader_counter.sv
// genericCounter
// Free-running modulo counter used as the column slot divider.
// Counts 0..COUNTER_MAX while ENABLE_IN is high and holds otherwise.
//   CLK       : system clock
//   RESET     : synchronous active-high reset (count returns to 0)
//   ENABLE_IN : count enable
//   TRIG_OUT  : high on the last count of each period (combinational)
module genericCounter #(
  parameter int COUNTER_WIDTH = 17,
  parameter int COUNTER_MAX   = 99999
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE_IN,
  output logic TRIG_OUT
);

  localparam logic [COUNTER_WIDTH-1:0] MAX_VAL = COUNTER_WIDTH'(COUNTER_MAX);
  localparam logic [COUNTER_WIDTH-1:0] ONE     = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d  = count_q;
    TRIG_OUT = 1'b0;
    if (ENABLE_IN) begin
      if (count_q == MAX_VAL) begin
        count_d  = '0;
        TRIG_OUT = 1'b1;
      end else begin
        count_d = count_q + ONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/keypad_bus_reader.sv
// keypad_bus_reader
// Bus-mapped 4x4 matrix keypad: scans columns, debounces the row returns
// and holds the accepted key code for the processor to read.
// Registers (BASE_ADDR relative):
//   +0 status {5'b0, irq_built, overflow, valid}; any write clears valid+overflow
//   +1 key    {4'b0, code};                       a read clears valid
// Ports:
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : address / write-enable (slave modport)
//   BUS_DATA   : bidirectional data, driven only for the read response cycle
//   KEY_COL    : active-low one-hot column drive
//   KEY_ROW    : active-low row sense (asynchronous, synchronised here)
//   KEY_IRQ    : registered copy of valid, only when KEYPAD_IRQ_EN is defined
// Build option: define KEYPAD_IRQ_EN to add KEY_IRQ and set status bit 2.
module keypad_bus_reader
  import keypad_bus_reader_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR      = 8'hE0,
  parameter int         SCAN_DIV       = 99999,
  parameter int         DEBOUNCE_SCANS = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  keypad_bus_reader_if.slave        bus,
  inout  wire  [7:0]                BUS_DATA,
  output logic [3:0]                KEY_COL,
  input  logic [3:0]                KEY_ROW
`ifdef KEYPAD_IRQ_EN
  ,
  output logic                      KEY_IRQ
`endif
);

  localparam logic [7:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;
  localparam logic [7:0] KEY_ADDR    = BASE_ADDR + KEY_OFS;
  localparam logic [3:0] DEB_TARGET  = 4'(DEBOUNCE_SCANS);
  localparam logic [3:0] CNT_SAT     = 4'd15;
`ifdef KEYPAD_IRQ_EN
  localparam logic IRQ_BUILT = 1'b1;
`else
  localparam logic IRQ_BUILT = 1'b0;
`endif

  // Scan path
  logic [3:0]       row_s1_q, row_s1_d;
  logic [3:0]       row_s2_q, row_s2_d;
  scan_state_e      state_q, state_d;
  logic [3:0][3:0]  row_cap_q, row_cap_d;
  logic [3:0]       key_col_q, key_col_d;
  logic             slot_trig;

  // Debounce
  logic [4:0]       prev_raw_q, prev_raw_d;
  logic [3:0]       stable_cnt_q, stable_cnt_d;
  logic             held_q, held_d;
  logic [4:0]       raw_code;
  logic [3:0]       cnt_scan;
  logic             in_eval;
  logic             accept;

  // Key registers and bus slave
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_key_q, rd_key_d;
  logic             oe_q, oe_d;
  logic [7:0]       dout_q, dout_d;
  logic             rd_clr;
  logic             wr_clr;
  logic [7:0]       status_reg;
  logic [7:0]       key_reg;

  // Slot divider; held at zero during EVAL so every slot starts fresh.
  genericCounter #(
    .COUNTER_WIDTH (17),
    .COUNTER_MAX   (SCAN_DIV)
  ) u_slot_div (
    .CLK       (CLK),
    .RESET     (RESET),
    .ENABLE_IN (state_q != EVAL),
    .TRIG_OUT  (slot_trig)
  );

  // Scan FSM next state, row capture on the last slot cycle.
  always_comb begin
    row_s1_d  = KEY_ROW;
    row_s2_d  = row_s1_q;
    state_d   = state_q;
    row_cap_d = row_cap_q;
    case (state_q)
      DRIVE0: if (slot_trig) begin row_cap_d[0] = row_s2_q; state_d = DRIVE1; end
      DRIVE1: if (slot_trig) begin row_cap_d[1] = row_s2_q; state_d = DRIVE2; end
      DRIVE2: if (slot_trig) begin row_cap_d[2] = row_s2_q; state_d = DRIVE3; end
      DRIVE3: if (slot_trig) begin row_cap_d[3] = row_s2_q; state_d = EVAL;   end
      EVAL:    state_d = DRIVE0;
      default: state_d = DRIVE0;
    endcase
    // Column pins are registered from the next state so they track state_q
    // exactly without decode glitches on the outputs.
    key_col_d = col_drive(state_d);
  end

  // Debounce: evaluated once per scan, in the single EVAL cycle.
  always_comb begin
    in_eval  = (state_q == EVAL);
    raw_code = first_key(row_cap_q);
    if (raw_code != prev_raw_q) begin
      cnt_scan = 4'd1;
    end else if (stable_cnt_q == CNT_SAT) begin
      cnt_scan = CNT_SAT;
    end else begin
      cnt_scan = stable_cnt_q + 4'd1;
    end
    accept = in_eval && (cnt_scan == DEB_TARGET) && (raw_code != CODE_NONE) && !held_q;

    prev_raw_d   = prev_raw_q;
    stable_cnt_d = stable_cnt_q;
    held_d       = held_q;
    if (in_eval) begin
      prev_raw_d   = raw_code;
      stable_cnt_d = cnt_scan;
      if (accept) begin
        held_d = 1'b1;
      end else if ((raw_code == CODE_NONE) && (cnt_scan == DEB_TARGET)) begin
        held_d = 1'b0;
      end
    end
  end

  // Bus slave and key registers.
  always_comb begin
    status_reg = {5'b0, IRQ_BUILT, ovf_q, valid_q};
    key_reg    = {4'b0, code_q};

    // Stage 1: register a matching read request.
    rd_pend_d = !bus.BUS_WE && ((bus.BUS_ADDR == STATUS_ADDR) || (bus.BUS_ADDR == KEY_ADDR));
    rd_key_d  = (bus.BUS_ADDR == KEY_ADDR);

    // Stage 2: load the response from the pre-edge register values, so a
    // coincident accept is reflected only in the following read.
    oe_d   = rd_pend_q;
    dout_d = rd_key_q ? key_reg : status_reg;
    rd_clr = rd_pend_q && rd_key_q;
    wr_clr = bus.BUS_WE && (bus.BUS_ADDR == STATUS_ADDR);

    code_d  = code_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (wr_clr) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end
    if (rd_clr) begin
      valid_d = 1'b0;
    end
    // An accept sees valid as already cleared by a same-cycle read or write.
    if (accept) begin
      if (valid_q && !rd_clr && !wr_clr) begin
        ovf_d = 1'b1;
      end else begin
        code_d  = raw_code[3:0];
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      row_s1_q     <= 4'hF;
      row_s2_q     <= 4'hF;
      state_q      <= DRIVE0;
      row_cap_q    <= '1;
      key_col_q    <= 4'b1110;
      prev_raw_q   <= CODE_NONE;
      stable_cnt_q <= 4'd0;
      held_q       <= 1'b0;
      code_q       <= 4'd0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_key_q     <= 1'b0;
      oe_q         <= 1'b0;
      dout_q       <= 8'd0;
    end else begin
      row_s1_q     <= row_s1_d;
      row_s2_q     <= row_s2_d;
      state_q      <= state_d;
      row_cap_q    <= row_cap_d;
      key_col_q    <= key_col_d;
      prev_raw_q   <= prev_raw_d;
      stable_cnt_q <= stable_cnt_d;
      held_q       <= held_d;
      code_q       <= code_d;
      valid_q      <= valid_d;
      ovf_q        <= ovf_d;
      rd_pend_q    <= rd_pend_d;
      rd_key_q     <= rd_key_d;
      oe_q         <= oe_d;
      dout_q       <= dout_d;
    end
  end

  assign KEY_COL  = key_col_q;
  assign BUS_DATA = oe_q ? dout_q : 8'bz;

`ifdef KEYPAD_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = valid_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign KEY_IRQ = irq_q;
`endif

endmodule
